// File: rtl/serial_bus_arbiter_rr_if.sv
// Serial bus arbiter bundle: master serial lines, grant, captured address
// and decoder handshake. "master" is the arbiter side, "slave" the bus side.
interface serial_bus_arbiter_rr_if #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 2
);
    logic [N_MASTERS-1:0] m_tx;
    logic [N_MASTERS-1:0] m_rx;
    logic [N_MASTERS-1:0] grant;
    logic [ADDR_W-1:0]    addr;
    logic                 addr_rdy;
    logic                 slv_ready;
    logic                 slv_responded;
    logic                 timeout_err;

    modport master (
        input  m_tx, slv_ready, slv_responded,
        output m_rx, grant, addr, addr_rdy, timeout_err
    );

    modport slave (
        output m_tx, slv_ready, slv_responded,
        input  m_rx, grant, addr, addr_rdy, timeout_err
    );
endinterface

// File: rtl/serial_bus_arbiter_rr.sv
// Round-robin N-master serial bus arbiter: grant, ACK, shift in the slave
// address, wait for the decoder with timeout, NACK on bad address/timeout.
// Ports: clk, rstn (async, active-low), bus (master modport of the _if).
module serial_bus_arbiter_rr #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned N_SLAVES  = 3,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    serial_bus_arbiter_rr_if.master bus
);
    localparam int unsigned GW = $clog2(N_MASTERS);
    localparam int unsigned CW = $clog2(ADDR_W + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, ACK, ADDR, WAIT_SLV, BUSY, NACK
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        last_q, last_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 to_q, to_d;

    logic                 found;
    logic [GW-1:0]        winner;
    logic [ADDR_W:0]      shift;

    // First requester searching upward from last+1, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            int unsigned idx;
            idx = (32'(last_q) + i) % N_MASTERS;
            if (!found && bus.m_tx[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    // last_q doubles as the granted index while the bus is owned.
    assign shift = {addr_q, bus.m_tx[last_q]};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    last_d          = winner;
                    state_d         = ACK;
                end
            end
            ACK: begin
                cnt_d   = '0;
                state_d = ADDR;
            end
            ADDR: begin
                addr_d = shift[ADDR_W-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(ADDR_W - 1)) begin
                    tmr_d = '0;
                    to_d  = 1'b0;
                    if (32'(addr_d) < N_SLAVES) begin
                        state_d = WAIT_SLV;
                    end else begin
                        state_d = NACK;
                    end
                end
            end
            WAIT_SLV: begin
                if (tmr_q != '1) begin
                    tmr_d = tmr_q + 1'b1;
                end
                if (bus.slv_ready) begin
                    state_d = BUSY;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = NACK;
                end
            end
            BUSY: begin
                if (bus.slv_responded) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            NACK: begin
                grant_d = '0;
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            last_q  <= GW'(N_MASTERS - 1);
            grant_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            to_q    <= to_d;
        end
    end

    // Moore outputs: decoded from registered state only.
    assign bus.grant       = grant_q;
    assign bus.addr        = addr_q;
    assign bus.m_rx        = (state_q == ACK || state_q == NACK) ? grant_q : '0;
    assign bus.addr_rdy    = (state_q == WAIT_SLV) && (tmr_q == '0);
    assign bus.timeout_err = (state_q == NACK) && to_q;
endmodule

// File: tb/tb_serial_bus_arbiter_rr.sv
// Directed bench for serial_bus_arbiter_rr: a 2-master instance for the
// protocol scenarios and a 4-master instance for round-robin ordering.
module tb_serial_bus_arbiter_rr;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_bus_arbiter_rr_if #(.N_MASTERS(2), .ADDR_W(2)) ia ();
    serial_bus_arbiter_rr_if #(.N_MASTERS(4), .ADDR_W(2)) ib ();

    serial_bus_arbiter_rr #(
        .N_MASTERS(2), .N_SLAVES(3), .ADDR_W(2), .TIMEOUT(16)
    ) dut_a (
        .clk(clk), .rstn(rstn), .bus(ia)
    );

    serial_bus_arbiter_rr #(
        .N_MASTERS(4), .N_SLAVES(4), .ADDR_W(2), .TIMEOUT(16)
    ) dut_b (
        .clk(clk), .rstn(rstn), .bus(ib)
    );

    task automatic test_reset();
        ia.m_tx = '0; ia.slv_ready = 1'b0; ia.slv_responded = 1'b0;
        ib.m_tx = '0; ib.slv_ready = 1'b0; ib.slv_responded = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL rst_grant_a: got %b expected 00", ia.grant); end
        checks++; if (ia.m_rx !== 2'b00) begin errors++; $display("FAIL rst_m_rx_a: got %b expected 00", ia.m_rx); end
        checks++; if (ia.addr !== 2'd0) begin errors++; $display("FAIL rst_addr_a: got %0d expected 0", ia.addr); end
        checks++; if (ia.addr_rdy !== 1'b0) begin errors++; $display("FAIL rst_addr_rdy_a: got %b expected 0", ia.addr_rdy); end
        checks++; if (ia.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_a: got %b expected 0", ia.timeout_err); end
        checks++; if (ib.grant !== 4'b0000) begin errors++; $display("FAIL rst_grant_b: got %b expected 0000", ib.grant); end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk); ia.m_tx = 2'b10;
        @(negedge clk);
        checks++; if (ia.m_rx !== 2'b10) begin errors++; $display("FAIL basic_ack: got %b expected 10", ia.m_rx); end
        checks++; if (ia.grant !== 2'b10) begin errors++; $display("FAIL basic_grant: got %b expected 10", ia.grant); end
        @(negedge clk); ia.m_tx[1] = 1'b1;
        @(negedge clk); ia.m_tx[1] = 1'b0;
        @(negedge clk);
        checks++; if (ia.addr_rdy !== 1'b1) begin errors++; $display("FAIL basic_addr_rdy: got %b expected 1", ia.addr_rdy); end
        checks++; if (ia.addr !== 2'd2) begin errors++; $display("FAIL basic_addr: got %0d expected 2", ia.addr); end
        checks++; if (ia.m_rx !== 2'b00) begin errors++; $display("FAIL basic_no_rx: got %b expected 00", ia.m_rx); end
        @(negedge clk); ia.slv_ready = 1'b1;
        checks++; if (ia.addr_rdy !== 1'b0) begin errors++; $display("FAIL basic_addr_rdy_pulse: got %b expected 0", ia.addr_rdy); end
        @(negedge clk); ia.slv_ready = 1'b0;
        checks++; if (ia.grant !== 2'b10) begin errors++; $display("FAIL basic_busy_grant: got %b expected 10", ia.grant); end
        @(negedge clk); ia.slv_responded = 1'b1;
        @(negedge clk); ia.slv_responded = 1'b0;
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL basic_release: got %b expected 00", ia.grant); end
    endtask

    task automatic test_bad_addr();
        @(negedge clk); ia.m_tx = 2'b01;
        @(negedge clk);
        checks++; if (ia.m_rx !== 2'b01) begin errors++; $display("FAIL nack_ack: got %b expected 01", ia.m_rx); end
        @(negedge clk); ia.m_tx[0] = 1'b1;
        @(negedge clk); ia.m_tx[0] = 1'b1;
        @(negedge clk); ia.m_tx = 2'b00;
        checks++; if (ia.m_rx !== 2'b01) begin errors++; $display("FAIL nack_pulse: got %b expected 01", ia.m_rx); end
        checks++; if (ia.addr_rdy !== 1'b0) begin errors++; $display("FAIL nack_addr_rdy: got %b expected 0", ia.addr_rdy); end
        checks++; if (ia.timeout_err !== 1'b0) begin errors++; $display("FAIL nack_timeout: got %b expected 0", ia.timeout_err); end
        checks++; if (ia.addr !== 2'd3) begin errors++; $display("FAIL nack_addr: got %0d expected 3", ia.addr); end
        @(negedge clk);
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL nack_release: got %b expected 00", ia.grant); end
        checks++; if (ia.m_rx !== 2'b00) begin errors++; $display("FAIL nack_rx_end: got %b expected 00", ia.m_rx); end
    endtask

    task automatic test_timeout();
        @(negedge clk); ia.m_tx = 2'b10;
        @(negedge clk);
        @(negedge clk); ia.m_tx[1] = 1'b0;
        @(negedge clk); ia.m_tx[1] = 1'b1;
        @(negedge clk); ia.m_tx = 2'b00;
        checks++; if (ia.addr !== 2'd1) begin errors++; $display("FAIL to_addr: got %0d expected 1", ia.addr); end
        repeat (15) @(negedge clk);
        checks++; if (ia.m_rx !== 2'b00) begin errors++; $display("FAIL to_early_rx: got %b expected 00", ia.m_rx); end
        checks++; if (ia.timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_err: got %b expected 0", ia.timeout_err); end
        @(negedge clk);
        checks++; if (ia.m_rx !== 2'b10) begin errors++; $display("FAIL to_nack_rx: got %b expected 10", ia.m_rx); end
        checks++; if (ia.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", ia.timeout_err); end
        @(negedge clk);
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL to_release: got %b expected 00", ia.grant); end
        checks++; if (ia.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b expected 0", ia.timeout_err); end
    endtask

    task automatic test_ready_at_limit();
        @(negedge clk); ia.m_tx = 2'b01;
        @(negedge clk);
        @(negedge clk); ia.m_tx[0] = 1'b0;
        @(negedge clk); ia.m_tx[0] = 1'b0;
        @(negedge clk);
        checks++; if (ia.addr_rdy !== 1'b1) begin errors++; $display("FAIL lim_addr_rdy: got %b expected 1", ia.addr_rdy); end
        repeat (15) @(negedge clk);
        ia.slv_ready = 1'b1;
        @(negedge clk); ia.slv_ready = 1'b0;
        checks++; if (ia.m_rx !== 2'b00) begin errors++; $display("FAIL lim_no_nack: got %b expected 00", ia.m_rx); end
        checks++; if (ia.timeout_err !== 1'b0) begin errors++; $display("FAIL lim_no_err: got %b expected 0", ia.timeout_err); end
        checks++; if (ia.grant !== 2'b01) begin errors++; $display("FAIL lim_busy: got %b expected 01", ia.grant); end
        ia.slv_responded = 1'b1;
        @(negedge clk); ia.slv_responded = 1'b0;
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL lim_release: got %b expected 00", ia.grant); end
    endtask

    task automatic test_resp_ignored();
        @(negedge clk); ia.m_tx = 2'b10;
        @(negedge clk);
        @(negedge clk); ia.m_tx[1] = 1'b1;
        @(negedge clk); ia.m_tx[1] = 1'b0;
        @(negedge clk); ia.slv_responded = 1'b1;
        @(negedge clk); ia.slv_responded = 1'b0;
        checks++; if (ia.grant !== 2'b10) begin errors++; $display("FAIL ign_grant: got %b expected 10", ia.grant); end
        checks++; if (ia.m_rx !== 2'b00) begin errors++; $display("FAIL ign_rx: got %b expected 00", ia.m_rx); end
        @(negedge clk); ia.slv_ready = 1'b1;
        @(negedge clk); ia.slv_ready = 1'b0;
        checks++; if (ia.grant !== 2'b10) begin errors++; $display("FAIL ign_busy: got %b expected 10", ia.grant); end
        ia.slv_responded = 1'b1;
        @(negedge clk); ia.slv_responded = 1'b0;
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL ign_release: got %b expected 00", ia.grant); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); ia.m_tx = 2'b10;
        @(negedge clk);
        checks++; if (ia.grant !== 2'b10) begin errors++; $display("FAIL mid_grant: got %b expected 10", ia.grant); end
        @(negedge clk); ia.m_tx[1] = 1'b1;
        rstn = 1'b0;
        #1;
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL mid_rst_grant: got %b expected 00", ia.grant); end
        checks++; if (ia.m_rx !== 2'b00) begin errors++; $display("FAIL mid_rst_rx: got %b expected 00", ia.m_rx); end
        checks++; if (ia.addr !== 2'd0) begin errors++; $display("FAIL mid_rst_addr: got %0d expected 0", ia.addr); end
        checks++; if (ia.addr_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_addr_rdy: got %b expected 0", ia.addr_rdy); end
        checks++; if (ia.timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", ia.timeout_err); end
        @(negedge clk); rstn = 1'b1; ia.m_tx = 2'b11;
        @(negedge clk);
        checks++; if (ia.grant !== 2'b01) begin errors++; $display("FAIL mid_first: got %b expected 01", ia.grant); end
        checks++; if (ia.m_rx !== 2'b01) begin errors++; $display("FAIL mid_first_ack: got %b expected 01", ia.m_rx); end
        repeat (3) @(negedge clk);
        ia.m_tx = 2'b10;
        checks++; if (ia.m_rx !== 2'b01) begin errors++; $display("FAIL mid_nack: got %b expected 01", ia.m_rx); end
        @(negedge clk);
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL mid_idle: got %b expected 00", ia.grant); end
        @(negedge clk); ia.m_tx = 2'b00;
        checks++; if (ia.grant !== 2'b10) begin errors++; $display("FAIL mid_second: got %b expected 10", ia.grant); end
        repeat (3) @(negedge clk);
        ia.slv_ready = 1'b1;
        @(negedge clk); ia.slv_ready = 1'b0; ia.slv_responded = 1'b1;
        @(negedge clk); ia.slv_responded = 1'b0;
        checks++; if (ia.grant !== 2'b00) begin errors++; $display("FAIL mid_release: got %b expected 00", ia.grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        @(negedge clk);
        ib.m_tx = 4'hF; ib.slv_ready = 1'b1; ib.slv_responded = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            checks++; if (ib.grant !== 4'b0000) begin errors++; $display("FAIL rr_idle%0d: got %b expected 0000", k, ib.grant); end
            @(negedge clk);
            checks++; if (ib.grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, ib.grant, exp_g); end
            checks++; if (ib.m_rx !== exp_g) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", k, ib.m_rx, exp_g); end
            repeat (5) @(negedge clk);
        end
        ib.m_tx = 4'h0; ib.slv_ready = 1'b0; ib.slv_responded = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_bad_addr();
        test_timeout();
        test_ready_at_limit();
        test_resp_ignored();
        test_reset_mid();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
